// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch front end. Reads opcode bytes from program memory one at
// a time (at most one read outstanding), buffers them with their fetch
// address in a small prefetch FIFO, and hands them to the decoder with a
// valid/ready handshake. Handles PC increment, redirect (jump/branch/return)
// with flush of buffered and in-flight bytes, and a sticky halt.
//
// Optional feature macro: FETCH_PERF_EN
//   defined   : stall_cnt counts FETCH cycles with op_valid=0 (saturating)
//   undefined : stall_cnt is tied to zero
//
// Parameters
//   ADDR_W : program-memory address / PC width
//   DEPTH  : prefetch FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   mem_req        : one-cycle read request strobe to program memory
//   mem_addr       : read address, meaningful while mem_req=1
//   mem_valid      : read data return strobe (>=1 cycle after mem_req)
//   mem_rdata      : returned opcode byte
//   op_code        : FIFO head byte to the decoder (bit 7 = immediate form)
//   op_pc          : address op_code was fetched from
//   op_valid       : op_code/op_pc valid
//   op_ready       : decoder accepts op_code this cycle
//   redirect       : one-cycle pulse, jump/branch/return taken
//   redirect_addr  : new PC on redirect
//   halt           : halt request from decode
//   halted         : fetch permanently stopped until reset
//   stall_cnt      : count of FETCH cycles with op_valid=0 (optional)
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        op_code,
    output logic [ADDR_W-1:0] op_pc,
    output logic              op_valid,
    input  logic              op_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt,
    output logic              halted,
    output logic [15:0]       stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_FETCH  = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    // Control state
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              outstanding_q, outstanding_d;
    logic              drop_q, drop_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // FIFO storage (data only, never reset)
    logic [7:0]        code_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

    logic              in_fetch;
    logic              fifo_empty;
    logic              head_valid;
    logic              fire;
    logic              do_redirect;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  occupancy;

    assign in_fetch   = (state_q == ST_FETCH);
    assign fifo_empty = (count_q == '0);
    assign head_valid = in_fetch && !fifo_empty;

    // A return only counts when a read is actually in flight; stray strobes
    // (e.g. a response to a read issued before reset) are ignored.
    assign fire = mem_valid && outstanding_q;

    // Halt takes precedence over redirect; once halted, redirect is ignored.
    assign do_redirect = in_fetch && redirect && !halt;

    // Buffered entries plus the in-flight read may never exceed DEPTH, so a
    // returning byte always has a slot and nothing is ever lost.
    assign occupancy = count_q + CNT_W'(outstanding_q);

    assign issue = !rst && in_fetch && !halt && !redirect && !outstanding_q
                   && (occupancy < CNT_W'(DEPTH));

    assign push = fire && !drop_q && in_fetch && !do_redirect;
    assign pop  = head_valid && op_ready && !do_redirect;

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        tag_d         = tag_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (fire) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end

        if (issue) begin
            outstanding_d = 1'b1;
            tag_d         = pc_q;
            pc_d          = pc_q + ADDR_W'(1);
        end

        if (do_redirect) begin
            pc_d     = redirect_addr;
            // Only a read still in flight after this cycle needs dropping;
            // a return arriving together with the redirect is discarded here.
            drop_d   = outstanding_q && !mem_valid;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        if (in_fetch && halt) begin
            state_d = ST_HALTED;
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= '0;
            tag_q         <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tag_q         <= tag_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO data registers
    always_ff @(posedge clk) begin
        if (push) begin
            code_mem_q[wr_ptr_q] <= mem_rdata;
            pc_mem_q[wr_ptr_q]   <= tag_q;
        end
    end

    // Outputs: head entry is forced to zero when not valid so the decoder
    // never sees stale or uninitialised storage.
    assign mem_req  = issue;
    assign mem_addr = pc_q;
    assign op_valid = head_valid;
    assign op_code  = head_valid ? code_mem_q[rd_ptr_q] : 8'h00;
    assign op_pc    = head_valid ? pc_mem_q[rd_ptr_q]   : '0;
    assign halted   = (state_q == ST_HALTED);

`ifdef FETCH_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (in_fetch && !head_valid && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 16'h0000;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_valid = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  op_code;
    logic [7:0]  op_pc;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_addr = 8'h00;
    logic        halt = 1'b0;
    logic        halted;
    logic [15:0] stall_cnt;

    instr_fetch #(.ADDR_W(8), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_valid     (mem_valid),
        .mem_rdata     (mem_rdata),
        .op_code       (op_code),
        .op_pc         (op_pc),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .halted        (halted),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Program memory and responder
    logic [7:0] prog [256];
    int         lat = 1;
    logic       req_seen = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic       inject = 1'b0;
    logic       rsp_pending = 1'b0;
    int         rsp_wait = 0;
    logic [7:0] rsp_addr = 8'h00;

    initial begin
        for (int i = 0; i < 256; i++) prog[i] = 8'(i + 1);
    end

    always @(posedge clk) begin
        #2;
        if (rst) begin
            rsp_pending = 1'b0;
            mem_valid   = 1'b0;
        end else begin
            mem_valid = 1'b0;
            if (req_seen) begin
                rsp_pending = 1'b1;
                rsp_wait    = lat;
                rsp_addr    = req_addr;
            end
            if (rsp_pending) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    rsp_pending = 1'b0;
                    mem_valid   = 1'b1;
                    mem_rdata   = prog[rsp_addr];
                end
            end
            if (inject) begin
                mem_valid = 1'b1;
                mem_rdata = 8'hEE;
            end
        end
    end

    // Behavioural model: queue of {code, pc}, one in-flight flag, drop flag
    logic [15:0] m_q [$];
    logic [7:0]  m_pc = 8'h00;
    logic [7:0]  m_tag = 8'h00;
    logic        m_out = 1'b0;
    logic        m_drop = 1'b0;
    logic        m_halted = 1'b0;
    logic [15:0] m_stall = 16'h0000;

    // Observation logs for literal pins
    logic [15:0] hs_log [$];
    int          hs_cyc [$];
    logic [7:0]  rq_log [$];
    int          cyc = 0;

    always @(negedge clk) begin
        logic exp_ov, exp_req, fire;
        cyc++;
        if (rst) begin
            chk("rst_mem_req", mem_req, 1'b0);
            chk("rst_mem_addr", mem_addr, 8'h00);
            chk("rst_op_valid", op_valid, 1'b0);
            chk("rst_op_code", op_code, 8'h00);
            chk("rst_op_pc", op_pc, 8'h00);
            chk("rst_halted", halted, 1'b0);
            chk("rst_stall_cnt", stall_cnt, 16'h0000);
            m_q.delete();
            m_pc = 8'h00; m_tag = 8'h00; m_out = 1'b0; m_drop = 1'b0;
            m_halted = 1'b0; m_stall = 16'h0000;
            req_seen = 1'b0;
        end else begin
            exp_ov  = !m_halted && (m_q.size() > 0);
            exp_req = !m_halted && !m_out && !redirect && !halt && (m_q.size() < DEPTH);
            chk("op_valid", op_valid, exp_ov);
            if (exp_ov) begin
                chk("op_code", op_code, m_q[0][15:8]);
                chk("op_pc", op_pc, m_q[0][7:0]);
            end
            chk("mem_req", mem_req, exp_req);
            if (exp_req) chk("mem_addr", mem_addr, m_pc);
            chk("halted", halted, m_halted);
            chk("stall_cnt", stall_cnt, m_stall);

            req_seen = mem_req;
            req_addr = mem_addr;
            if (mem_req) rq_log.push_back(mem_addr);
            if (op_valid && op_ready && !redirect) begin
                hs_log.push_back({op_code, op_pc});
                hs_cyc.push_back(cyc);
            end

            fire = mem_valid && m_out;
            if (m_halted) begin
                if (fire) m_out = 1'b0;
            end else begin
`ifdef FETCH_PERF_EN
                if (!exp_ov && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
                if (redirect && !halt) begin
                    m_q.delete();
                    m_pc   = redirect_addr;
                    m_out  = m_out && !mem_valid;
                    m_drop = m_out;
                end else begin
                    if (exp_ov && op_ready) void'(m_q.pop_front());
                    if (fire) begin
                        m_out = 1'b0;
                        if (m_drop) m_drop = 1'b0;
                        else        m_q.push_back({mem_rdata, m_tag});
                    end
                    if (exp_req) begin
                        m_out = 1'b1;
                        m_tag = m_pc;
                        m_pc  = m_pc + 8'd1;
                    end
                end
                if (halt) m_halted = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int new_lat);
        tick();
        rst = 1'b1; redirect = 1'b0; halt = 1'b0; op_ready = 1'b0; inject = 1'b0;
        lat = new_lat;
        tick();
        hs_log.delete(); hs_cyc.delete(); rq_log.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input logic [7:0] a, input string name);
        logic found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            #1;
            if (mem_req && mem_addr == a) found = 1'b1;
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL %s: request for addr 0x%0h not seen within 60 cycles", name, a);
        end
    endtask

    task automatic pin_hs(input int idx, input logic [7:0] code, input logic [7:0] pc, input string name);
        chk({name, "_present"}, hs_log.size() > idx, 1'b1);
        if (hs_log.size() > idx) chk(name, hs_log[idx], {code, pc});
    endtask

    task automatic pin_rq(input int idx, input logic [7:0] a, input string name);
        chk({name, "_present"}, rq_log.size() > idx, 1'b1);
        if (rq_log.size() > idx) chk(name, rq_log[idx], a);
    endtask

    initial begin
        int n, m, bad;

        // Sequential fetch, latency 1, always ready
        do_reset(1);
        op_ready = 1'b1;
        repeat (7) tick();
        pin_rq(0, 8'h00, "seq_req0");
        pin_rq(1, 8'h01, "seq_req1");
        pin_rq(2, 8'h02, "seq_req2");
        pin_hs(0, 8'h01, 8'h00, "seq_hs0");
        pin_hs(1, 8'h02, 8'h01, "seq_hs1");
        pin_hs(2, 8'h03, 8'h02, "seq_hs2");
        if (hs_cyc.size() > 2) begin
            chk("seq_rate01", hs_cyc[1] - hs_cyc[0], 2);
            chk("seq_rate12", hs_cyc[2] - hs_cyc[1], 2);
        end

        // Back-pressure: FIFO fills, stray return ignored, then drain
        do_reset(1);
        repeat (10) tick();
        chk("full_req_count", rq_log.size(), 2);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        repeat (2) tick();
        chk("full_req_count_after_stray", rq_log.size(), 2);
        op_ready = 1'b1;
        repeat (6) tick();
        pin_hs(0, 8'h01, 8'h00, "drain_hs0");
        pin_hs(1, 8'h02, 8'h01, "drain_hs1");
        pin_rq(2, 8'h02, "drain_resume_req");

        // Redirect while read of addr 3 is in flight (latency 3)
        do_reset(3);
        op_ready = 1'b1;
        wait_req(8'h03, "redir_wait");
        n = rq_log.size();
        tick();
        m = hs_log.size();
        redirect = 1'b1; redirect_addr = 8'h40;
        tick();
        redirect = 1'b0;
        repeat (12) tick();
        pin_rq(n, 8'h40, "redir_next_req");
        pin_hs(m, 8'h41, 8'h40, "redir_next_hs");
        bad = 0;
        foreach (hs_log[i]) if (hs_log[i][7:0] == 8'h03) bad++;
        chk("redir_addr3_never_delivered", bad, 0);

        // Redirect coinciding with the return of addr 3 (latency 1)
        do_reset(1);
        op_ready = 1'b1;
        wait_req(8'h03, "redir_same_wait");
        n = rq_log.size();
        tick();
        m = hs_log.size();
        redirect = 1'b1; redirect_addr = 8'h80;
        tick();
        redirect = 1'b0;
        repeat (6) tick();
        pin_rq(n, 8'h80, "redir_same_next_req");
        pin_hs(m, 8'h81, 8'h80, "redir_same_next_hs");

        // PC wrap 0xFF -> 0x00
        do_reset(1);
        op_ready = 1'b1;
        redirect = 1'b1; redirect_addr = 8'hFF;
        tick();
        redirect = 1'b0;
        repeat (6) tick();
        pin_rq(0, 8'hFF, "wrap_req0");
        pin_rq(1, 8'h00, "wrap_req1");
        pin_hs(0, 8'h00, 8'hFF, "wrap_hs0");
        pin_hs(1, 8'h01, 8'h00, "wrap_hs1");

        // Halt with a read in flight; redirect ignored; reset clears
        do_reset(3);
        op_ready = 1'b1;
        wait_req(8'h00, "halt_wait");
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        @(negedge clk); #1;
        chk("halt_halted", halted, 1'b1);
        chk("halt_op_valid", op_valid, 1'b0);
        tick();
        redirect = 1'b1; redirect_addr = 8'h10;
        tick();
        redirect = 1'b0;
        repeat (8) tick();
        chk("halt_no_more_req", rq_log.size(), 1);
        chk("halt_no_hs", hs_log.size(), 0);
        do_reset(1);
        @(negedge clk); #1;
        chk("halt_cleared_by_rst", halted, 1'b0);

        // Stall counter: 5 idle cycles after reset (latency 6)
        do_reset(6);
        op_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
`ifdef FETCH_PERF_EN
        chk("stall_after5", stall_cnt, 16'd5);
`else
        chk("stall_after5", stall_cnt, 16'd0);
`endif
        repeat (10) tick();

        // Reset asserted while a read is in flight
        do_reset(4);
        op_ready = 1'b1;
        wait_req(8'h00, "midrst_wait");
        do_reset(1);
        op_ready = 1'b1;
        repeat (5) tick();
        pin_hs(0, 8'h01, 8'h00, "midrst_hs0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch front end: producer side of the 8-bit op_code interface consumed by the control decoder.
- Fetches opcode bytes from program memory, buffers them in a small prefetch FIFO, and presents one op_code per handshake to decode.
- Handles PC increment, jump/branch redirect with flush, and the halt request raised by decode.

Parameters:
- ADDR_W, 8, program-memory address / PC width
- DEPTH, 2, prefetch FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- mem_req  out  1  one-cycle read request strobe to program memory
- mem_addr  out  ADDR_W  read address; valid when mem_req=1
- mem_valid  in  1  read data return strobe; latency >=1 cycle after mem_req
- mem_rdata  in  8  returned opcode byte
- op_code  out  8  FIFO head byte to decoder (bit 7 = immediate form)
- op_pc  out  ADDR_W  address op_code was fetched from
- op_valid  out  1  op_code/op_pc valid
- op_ready  in  1  decoder/execute accepts op_code this cycle
- redirect  in  1  one-cycle pulse: jump/branch/return taken
- redirect_addr  in  ADDR_W  new PC on redirect
- halt  in  1  halt request from decode (halt control bit)
- halted  out  1  fetch stopped
- stall_cnt  out  16  op_valid=0 cycle counter (see Optional Feature)

Behaviour:
- Reset (async, immediate): pc=0, FIFO empty, outstanding=0, drop=0, state FETCH; outputs mem_req=0, mem_addr=0, op_code=0, op_pc=0, op_valid=0, halted=0, stall_cnt=0.
- States: FETCH, HALTED. Max one outstanding memory read.
- Issue: in FETCH when outstanding=0, redirect=0, and (count+outstanding)<DEPTH -> mem_req=1, mem_addr=pc for exactly one cycle; pc<=pc+1 mod 2^ADDR_W (0xFF -> 0x00 for ADDR_W=8); outstanding<=1; request address saved as tag.
- Return: mem_valid with outstanding=1 -> outstanding<=0; if drop=0 push {mem_rdata, tag} into FIFO, else discard and clear drop. Next issue is earliest the cycle after mem_valid. mem_valid with outstanding=0 is ignored.
- Output: op_valid = FIFO non-empty and state FETCH; op_code/op_pc = head entry (registered FIFO storage; no comb path from mem_rdata). Pop on op_valid && op_ready.
- Push and pop in the same cycle are both performed; count unchanged.
- Full: no issue while count+outstanding=DEPTH; no data ever lost.
- Redirect (priority over push, pop, issue that cycle): FIFO flushed, pc<=redirect_addr, drop<=outstanding; op_valid=0 the following cycle; first request to redirect_addr issues the cycle after redirect if outstanding=0, else the cycle after the dropped return.
- Redirect and mem_valid in the same cycle: return is discarded.
- Halt: halt=1 in FETCH -> state HALTED next edge; halted=1, op_valid=0, no further issue, redirect ignored; outstanding return absorbed and discarded. Leave HALTED only by reset.
- Halt and redirect in the same cycle: halt wins.
- Reset mid-transaction: state cleared immediately; a later mem_valid with outstanding=0 is ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: stall_cnt increments every cycle in FETCH with op_valid=0, saturating at 0xFFFF; cleared only by rst; frozen in HALTED.
- Undefined: stall_cnt tied to 0; no counter logic.

Test Plan:
- Reset release, memory latency 1, bytes 0x01,0x02,0x03 at 0..2, op_ready=1 -> mem_addr 0,1,2 in order; op_code 0x01/op_pc 0, then 0x02/1, then 0x03/2; one byte per 2 cycles.
- op_ready=0 with DEPTH=2 -> exactly 2 requests issued, then mem_req stays 0; op_ready=1 -> 0x01 then 0x02 delivered, issue resumes at addr 2.
- Redirect to 0x40 while read of addr 3 is outstanding -> addr-3 data never on op_code; next mem_addr=0x40 after the dropped return; next op_pc=0x40.
- pc=0xFF, ADDR_W=8 -> fetch 0xFF then mem_addr 0x00; op_pc sequence 0xFF, 0x00.
- halt=1 with one outstanding read -> halted=1 next cycle, op_valid=0, no mem_req; return absorbed; redirect ignored; rst clears halted.
- FETCH_PERF_EN defined, 5 consecutive cycles of op_valid=0 after reset -> stall_cnt=5; undefined -> stall_cnt=0 throughout.
